// File: rtl/speed_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speed_display_pkg
//  Description : Shared types and constants for the speed display stage.
//                Holds the converter state enum, the active-low 7-segment
//                digit table, the blank pattern, the digit-enable reset
//                value and the double-dabble nibble adjust helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package speed_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Segment order is {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Packed table: element [n] is the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Units digit enabled out of reset.
    localparam logic [2:0] AN_RESET = 3'b110;

    // Double-dabble correction: a nibble of 5 or more would reach 10 or more
    // after the shift, so pre-add 3 to carry into the next decade.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/speed_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : speed_display_if
//  Description : Bus between the speed source and the display stage.
//                speed : 8-bit unsigned speed word into the display
//                seg   : 7-bit active-low segment drive
//                an    : 3-bit active-low digit enable (an[0] = units)
//                upd   : one-cycle pulse when new digits are loaded
//                master drives speed and observes the display outputs;
//                slave is the display stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface speed_display_if;
    logic [7:0] speed;
    logic [6:0] seg;
    logic [2:0] an;
    logic       upd;

    modport master (output speed, input seg, input an, input upd);
    modport slave  (input speed, output seg, output an, output upd);
endinterface
`default_nettype wire

// File: rtl/speed_display_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD digit to active-low 7-segment pattern.
//                digit : 4-bit BCD input (10..15 decode to blank)
//                blank : forces the blank pattern when high
//                seg   : 7-bit active-low pattern, seg[0] = a .. seg[6] = g
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import speed_display_pkg::*;
(
    input  wire logic [3:0] digit,
    input  wire logic       blank,
    output logic      [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule
`default_nettype wire

// File: rtl/speed_display.sv
`default_nettype none
// ============================================================================
//  Module      : speed_display
//  Description : Converts an 8-bit speed word to three BCD digits with a
//                sequential double-dabble engine (one iteration per cycle)
//                and scans them onto a multiplexed common-anode 3-digit
//                7-segment display.
//                clk   : system clock
//                reset : synchronous active-high reset
//                bus   : speed_display_if.slave (speed in; seg, an, upd out)
//                DWELL_CYC : cycles each digit stays enabled
//                Build option SPEED_DISPLAY_BLANK_EN enables leading-zero
//                blanking of the hundreds and tens digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module speed_display
    import speed_display_pkg::*;
#(
    parameter int DWELL_CYC = 40000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    speed_display_if.slave  bus
);

    localparam int             c_DW         = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL_CYC - 1);

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    conv_state_t r_state;
    conv_state_t w_state_nxt;

    logic [19:0] r_sr;        // {bcd[11:0], bin[7:0]}
    logic [2:0]  r_cnt;       // shift iteration 0..7
    logic [7:0]  r_cap;       // value under conversion
    logic [7:0]  r_last;      // last value fully converted
    logic [3:0]  r_d2, r_d1, r_d0;
    logic        r_upd;

    logic        w_capture;
    logic        w_shift;
    logic        w_load;
    logic [11:0] w_adj;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.speed != r_last) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == 3'd7)       w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture = (r_state == ST_IDLE) && (bus.speed != r_last);
        w_shift   = (r_state == ST_SHIFT);
        w_load    = (r_state == ST_DONE);
    end

    assign w_adj = {bcd_adjust(r_sr[19:16]), bcd_adjust(r_sr[15:12]), bcd_adjust(r_sr[11:8])};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_cap  <= '0;
            r_last <= '0;
            r_d2   <= '0;
            r_d1   <= '0;
            r_d0   <= '0;
            r_upd  <= 1'b0;
        end else begin
            r_upd <= w_load;
            if (w_capture) begin
                r_sr  <= {12'd0, bus.speed};
                r_cap <= bus.speed;
                r_cnt <= '0;
            end else if (w_shift) begin
                // The top adjusted bit is dropped; 255 never fills it.
                r_sr  <= {w_adj[10:0], r_sr[7:0], 1'b0};
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_load) begin
                r_d2   <= r_sr[19:16];
                r_d1   <= r_sr[15:12];
                r_d0   <= r_sr[11:8];
                r_last <= r_cap;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scan. The digit about to be enabled is decoded ahead of the
    // switch edge so an and seg change together with no ghost cycle.
    // ------------------------------------------------------------------
    logic [c_DW-1:0] r_dwell;
    logic [1:0]      r_idx;
    logic [2:0]      r_an;
    logic [6:0]      r_seg;

    logic            w_wrap;
    logic [1:0]      w_idx_nxt;
    logic [3:0]      w_digit;
    logic            w_blank;
    logic [6:0]      w_seg;

    assign w_wrap    = (r_dwell == c_DWELL_LAST);
    assign w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);

    always_comb begin
        w_digit = r_d0;
        w_blank = 1'b0;
        case (w_idx_nxt)
            2'd1:    w_digit = r_d1;
            2'd2:    w_digit = r_d2;
            default: w_digit = r_d0;
        endcase
`ifdef SPEED_DISPLAY_BLANK_EN
        if (w_idx_nxt == 2'd2) w_blank = (r_d2 == 4'd0);
        if (w_idx_nxt == 2'd1) w_blank = (r_d2 == 4'd0) && (r_d1 == 4'd0);
`endif
    end

    seg7_decode u_seg7_decode (
        .digit (w_digit),
        .blank (w_blank),
        .seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell <= '0;
            r_idx   <= 2'd0;
            r_an    <= AN_RESET;
            r_seg   <= SEG_TABLE[0];
        end else if (w_wrap) begin
            r_dwell <= '0;
            r_idx   <= w_idx_nxt;
            r_an    <= ~(3'b001 << w_idx_nxt);
            r_seg   <= w_seg;
        end else begin
            r_dwell <= r_dwell + c_DW'(1);
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
    assign bus.upd = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_speed_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speed_display
//  Description : Self-checking bench for speed_display with DWELL_CYC = 4.
//                A cycle-level reference model derives upd/an/seg from the
//                decimal value and elapsed time; directed scenarios add
//                literal expectations on latency and scanned digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_display;

    localparam int DWELL = 4;

    logic clk;
    logic reset;
    speed_display_if bus();

    speed_display #(.DWELL_CYC(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected pattern for display position idx (0 units, 1 tens, 2 hundreds).
    function automatic logic [6:0] pat(input int v, input int idx);
        int   d;
        logic blank;
        d     = (idx == 0) ? (v % 10) : (idx == 1) ? ((v / 10) % 10) : (v / 100);
        blank = 1'b0;
`ifdef SPEED_DISPLAY_BLANK_EN
        if (idx == 2 && v < 100) blank = 1'b1;
        if (idx == 1 && v < 10)  blank = 1'b1;
`endif
        if (blank) return 7'b1111111;
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------- reference model ----------------
    logic       m_valid = 1'b0;
    int         m_t, m_phase, m_last, m_cap, m_disp, m_idx;
    logic       exp_upd;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic [2:0] m_one;

    always @(posedge clk) begin
        if (reset) begin
            m_t = 0; m_phase = 0; m_last = 0; m_cap = 0; m_disp = 0;
            exp_an = 3'b110; exp_seg = pat(0, 0); exp_upd = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            exp_upd = 1'b0;
            m_t++;
            if (m_t % DWELL == 0) begin
                m_idx   = (m_t / DWELL) % 3;
                m_one   = 3'b001 << m_idx;
                exp_an  = ~m_one;
                exp_seg = pat(m_disp, m_idx);   // value held before this edge
            end
            // Capture edge, then nine more edges until the digits land.
            if (m_phase == 9) begin
                m_disp = m_cap; m_last = m_cap; exp_upd = 1'b1; m_phase = 0;
            end else if (m_phase > 0) begin
                m_phase++;
            end else if (int'(bus.speed) != m_last) begin
                m_cap = int'(bus.speed); m_phase = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("upd", 32'(bus.upd), 32'(exp_upd));
            chk("an",  32'(bus.an),  32'(exp_an));
            chk("seg", 32'(bus.seg), 32'(exp_seg));
        end
        if (bus.upd) upd_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_upd(input string name, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.upd) found = 1'b1;
        end
        if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic scan(input logic [2:0] an_pat, input logic [6:0] exp, input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.an == an_pat) found = 1'b1;
        end
        if (!found) chk({name, "_an_timeout"}, 32'd0, 32'd1);
        else        chk(name, 32'(bus.seg), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int n, c0;

    initial begin
        reset     = 1'b1;
        bus.speed = 8'd0;
        tick(2);
        reset = 1'b0;

        // Reset state and scan order.
        @(negedge clk);
        chk("rst_an",  32'(bus.an),  32'b110);
        chk("rst_seg", 32'(bus.seg), 32'b1000000);
        chk("rst_upd", 32'(bus.upd), 32'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3)  chk("scan_k3",  32'(bus.an), 32'b110);
            if (k == 4)  chk("scan_k4",  32'(bus.an), 32'b101);
            if (k == 8)  chk("scan_k8",  32'(bus.an), 32'b011);
            if (k == 12) chk("scan_k12", 32'(bus.an), 32'b110);
        end
        chk("zero_no_upd", 32'(upd_cnt), 32'd0);

        // 255 -> 2,5,5 with 10-cycle latency.
        tick(1);
        bus.speed = 8'd255;
        wait_upd("c255", n);
        chk("lat255", 32'(n), 32'd10);
        chk("model255", 32'(m_disp), 32'd255);
        tick(16);
        scan(3'b110, 7'b0010010, "s255_u");
        scan(3'b101, 7'b0010010, "s255_t");
        scan(3'b011, 7'b0100100, "s255_h");

        // Change during conversion: 100 converted first, then 45.
        tick(1);
        bus.speed = 8'd100;
        tick(3);
        bus.speed = 8'd45;
        wait_upd("c100", n);
        chk("lat100", 32'(n), 32'd7);
        chk("model100", 32'(m_disp), 32'd100);
        wait_upd("c45", n);
        chk("lat45", 32'(n), 32'd10);
        chk("model45", 32'(m_disp), 32'd45);
        tick(16);
        scan(3'b110, 7'b0010010, "s45_u");
        scan(3'b101, 7'b0011001, "s45_t");
`ifdef SPEED_DISPLAY_BLANK_EN
        scan(3'b011, 7'b1111111, "s45_h");
`else
        scan(3'b011, 7'b1000000, "s45_h");
`endif

        // Small value: leading-zero behaviour.
        tick(1);
        bus.speed = 8'd7;
        wait_upd("c7", n);
        tick(16);
        scan(3'b110, 7'b1111000, "s7_u");
`ifdef SPEED_DISPLAY_BLANK_EN
        scan(3'b101, 7'b1111111, "s7_t");
        scan(3'b011, 7'b1111111, "s7_h");
`else
        scan(3'b101, 7'b1000000, "s7_t");
        scan(3'b011, 7'b1000000, "s7_h");
`endif

        // Reset in the middle of converting 200.
        tick(1);
        c0 = upd_cnt;
        bus.speed = 8'd200;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_upd_none", 32'(upd_cnt - c0), 32'd0);
        chk("midrst_seg", 32'(bus.seg), 32'b1000000);
        chk("midrst_an",  32'(bus.an),  32'b110);
        wait_upd("c200", n);
        chk("lat200", 32'(n), 32'd10);
        tick(16);
        scan(3'b110, 7'b1000000, "s200_u");
        scan(3'b101, 7'b1000000, "s200_t");
        scan(3'b011, 7'b0100100, "s200_h");

        // Stable input: exactly one conversion.
        tick(1);
        c0 = upd_cnt;
        bus.speed = 8'd137;
        repeat (1000) @(negedge clk);
        chk("stable_upd_cnt", 32'(upd_cnt - c0), 32'd1);
        scan(3'b110, 7'b1111000, "s137_u");
        scan(3'b101, 7'b0110000, "s137_t");
        scan(3'b011, 7'b1111001, "s137_h");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
